// File: rtl/pipe_reg_sync_clr_pkg.sv
// Shared helpers for the flushable valid/ready pipeline register.
// Holds the occupancy-counter width function and the DEPTH sanity check.
`ifndef PIPE_REG_SYNC_CLR_PKG_SV
`define PIPE_REG_SYNC_CLR_PKG_SV

package pipe_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// Stops elaboration when the pipeline is asked to have no stages at all.
`define PIPE_DEPTH_CHECK(D) \
    if ((D) < 1) begin : g_bad_depth \
        $error("pipe_reg_sync_clr: DEPTH must be >= 1"); \
    end

`endif

// File: rtl/pipe_reg_sync_clr_if.sv
// Producer/consumer handshake bundle for pipe_reg_sync_clr.
// The slave modport is the pipeline side, the master modport is the surrounding logic.
interface pipe_reg_sync_clr_if
    import pipe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = cnt_w(DEPTH);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_reg_sync_clr_stage.sv
// One word-plus-valid slot of the pipeline; loads from upstream whenever it is
// empty or its downstream neighbour is taking its current word this cycle.
module pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          syn_clr,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          dn_ready,
    output logic          v,
    output logic [DW-1:0] d,
    output logic          rdy
);
    logic          v_q, v_d;
    logic [DW-1:0] d_q, d_d;

    // Bubbles are loaded too (v=0), which is what lets a gap collapse.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        rdy = ~v_q | dn_ready;
        if (syn_clr) begin
            v_d = 1'b0;
            d_d = '0;
        end else if (rdy) begin
            v_d = up_valid;
            d_d = up_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;
endmodule

// File: rtl/pipe_reg_sync_clr.sv
// DEPTH-stage valid/ready pipeline register with synchronous flush and a
// registered occupancy count; ready ripples combinationally from the output back.
module pipe_reg_sync_clr
    import pipe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                syn_clr,
    pipe_reg_sync_clr_if.slave  bus
);
    localparam int CW = cnt_w(DEPTH);

    `PIPE_DEPTH_CHECK(DEPTH)

    logic          v_s [DEPTH];
    logic [DW-1:0] d_s [DEPTH];
    logic          rdy0;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_q, count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          up_v;
        logic [DW-1:0] up_d;
        logic          dn_r;
        logic          rdy;

        if (i == 0) begin : g_head
            assign up_v = bus.in_valid;
            assign up_d = bus.in_data;
        end else begin : g_body
            assign up_v = v_s[i-1];
            assign up_d = d_s[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_r = bus.out_ready;
        end else begin : g_link
            assign dn_r = g_stage[i+1].rdy;
        end

        pipe_stage #(.DW(DW)) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .syn_clr  (syn_clr),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_r),
            .v        (v_s[i]),
            .d        (d_s[i]),
            .rdy      (rdy)
        );
    end

    assign rdy0 = g_stage[0].rdy;

    // A flush cycle (or reset) blocks both handshakes so no word slips through it.
    assign bus.in_ready  = rdy0 & reset_n & ~syn_clr;
    assign bus.out_valid = v_s[DEPTH-1] & reset_n & ~syn_clr;
    assign bus.out_data  = d_s[DEPTH-1];
    assign bus.count     = count_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        count_d = count_q;
        if (syn_clr) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_sync_clr.sv
// Bench for pipe_reg_sync_clr: three instances (DEPTH 4/DW 8, DEPTH 1/DW 16, DEPTH 7/DW 16)
// share one stimulus stream and are each checked every cycle against a word/position model.
module tb_pipe_reg_sync_clr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        iv;
    logic [15:0] idat;
    logic        ordy;

    int n_vec    = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_reg_sync_clr_if #(.DW(8),  .DEPTH(4)) bus_a ();
    pipe_reg_sync_clr_if #(.DW(16), .DEPTH(1)) bus_b ();
    pipe_reg_sync_clr_if #(.DW(16), .DEPTH(7)) bus_c ();

    pipe_reg_sync_clr #(.DW(8),  .DEPTH(4)) dut_a (.clk(clk), .reset_n(rst_n), .syn_clr(clr), .bus(bus_a));
    pipe_reg_sync_clr #(.DW(16), .DEPTH(1)) dut_b (.clk(clk), .reset_n(rst_n), .syn_clr(clr), .bus(bus_b));
    pipe_reg_sync_clr #(.DW(16), .DEPTH(7)) dut_c (.clk(clk), .reset_n(rst_n), .syn_clr(clr), .bus(bus_c));

    assign bus_a.in_valid  = iv;
    assign bus_a.in_data   = idat[7:0];
    assign bus_a.out_ready = ordy;
    assign bus_b.in_valid  = iv;
    assign bus_b.in_data   = idat;
    assign bus_b.out_ready = ordy;
    assign bus_c.in_valid  = iv;
    assign bus_c.in_data   = idat;
    assign bus_c.out_ready = ordy;

    logic        dut_ir  [3];
    logic        dut_ov  [3];
    logic [15:0] dut_od  [3];
    logic [3:0]  dut_cnt [3];

    assign dut_ir[0]  = bus_a.in_ready;
    assign dut_ov[0]  = bus_a.out_valid;
    assign dut_od[0]  = {8'h00, bus_a.out_data};
    assign dut_cnt[0] = 4'(bus_a.count);
    assign dut_ir[1]  = bus_b.in_ready;
    assign dut_ov[1]  = bus_b.out_valid;
    assign dut_od[1]  = bus_b.out_data;
    assign dut_cnt[1] = 4'(bus_b.count);
    assign dut_ir[2]  = bus_c.in_ready;
    assign dut_ov[2]  = bus_c.out_valid;
    assign dut_od[2]  = bus_c.out_data;
    assign dut_cnt[2] = 4'(bus_c.count);

    // Model: per instance, the words in flight oldest-first with their stage position.
    int          dep [3] = '{4, 1, 7};
    logic [15:0] msk [3] = '{16'h00FF, 16'hFFFF, 16'hFFFF};
    logic [15:0] md  [3][8];
    int          mp  [3][8];
    int          mn  [3] = '{0, 0, 0};
    bit          mvalid [3] = '{1'b0, 1'b0, 1'b0};

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_cycle(input int k);
        int  dd;
        int  newp [8];
        bit  stays [8];
        bit  ev;
        bit  eir;
        bit  leave;
        bit  free0;
        int  s;
        dd    = dep[k];
        ev    = rst_n && !clr && (mn[k] > 0) && (mp[k][0] == dd - 1);
        leave = 1'b0;
        for (int j = 0; j < mn[k]; j++) begin
            if (mp[k][j] == dd - 1) begin
                stays[j] = !(ordy && ev);
                leave    = !stays[j];
                newp[j]  = stays[j] ? mp[k][j] : -1;
            end else if (j > 0 && stays[j-1] && newp[j-1] == mp[k][j] + 1) begin
                stays[j] = 1'b1;
                newp[j]  = mp[k][j];
            end else begin
                stays[j] = 1'b0;
                newp[j]  = mp[k][j] + 1;
            end
        end
        free0 = (mn[k] == 0) || (newp[mn[k]-1] != 0);
        eir   = rst_n && !clr && free0;

        if (mvalid[k]) begin
            chk("in_ready",  k, 32'(dut_ir[k]),  32'(eir));
            chk("out_valid", k, 32'(dut_ov[k]),  32'(ev));
            chk("count",     k, 32'(dut_cnt[k]), 32'(mn[k]));
            if (ev) chk("out_data", k, 32'(dut_od[k]), 32'(md[k][0]));
        end

        if (!rst_n) begin
            mn[k]     = 0;
            mvalid[k] = 1'b1;
        end else if (clr) begin
            mn[k] = 0;
        end else begin
            s = leave ? 1 : 0;
            for (int j = s; j < mn[k]; j++) begin
                md[k][j-s] = md[k][j];
                mp[k][j-s] = newp[j];
            end
            mn[k] = mn[k] - s;
            if (iv && eir) begin
                md[k][mn[k]] = idat & msk[k];
                mp[k][mn[k]] = 0;
                mn[k]        = mn[k] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) model_cycle(k);
    end

    task automatic step(input bit r, input bit c, input bit v, input logic [15:0] dat, input bit o);
        @(posedge clk);
        #1;
        rst_n = r;
        clr   = c;
        iv    = v;
        idat  = dat;
        ordy  = o;
        n_vec++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        clr   = 1'b0;
        iv    = 1'b0;
        idat  = 16'h0;
        ordy  = 1'b0;

        // Reset held with traffic offered
        step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        chk("rst_out_valid", 0, 32'(bus_a.out_valid), 32'd0);
        chk("rst_out_data",  0, 32'(bus_a.out_data),  32'd0);
        chk("rst_count",     0, 32'(bus_a.count),     32'd0);
        chk("rst_in_ready",  0, 32'(bus_a.in_ready),  32'd0);
        idle(2);
        chk("post_rst_in_ready", 0, 32'(bus_a.in_ready), 32'd1);

        // Back-to-back stream
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'(i), 1'b1);
            if (i == 4) chk("lat_not_yet", 0, 32'(bus_a.out_valid), 32'd0);
            if (i == 5) begin
                chk("lat_first_valid", 0, 32'(bus_a.out_valid), 32'd1);
                chk("lat_first_data",  0, 32'(bus_a.out_data),  32'h01);
                chk("stream_count",    0, 32'(bus_a.count),     32'd4);
            end
            if (i == 6) chk("stream_second", 0, 32'(bus_a.out_data), 32'h02);
        end
        idle(10);

        // Backpressure
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 1'b1, 16'(16'h00A0 + idx), 1'b0);
            if (bus_a.in_ready) idx++;
        end
        chk("bp_accepted", 0, 32'(idx),             32'd4);
        chk("bp_count",    0, 32'(bus_a.count),     32'd4);
        chk("bp_in_ready", 0, 32'(bus_a.in_ready),  32'd0);
        for (int c = 0; c < 20 && idx < 6; c++) begin
            step(1'b1, 1'b0, 1'b1, 16'(16'h00A0 + idx), 1'b1);
            if (c == 0) chk("bp_head", 0, 32'(bus_a.out_data), 32'hA0);
            if (bus_a.in_ready) idx++;
        end
        idle(10);

        // Full with simultaneous push and pop
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 1'b0, 1'b1, 16'(16'h00B0 + idx), 1'b0);
            if (bus_a.in_ready) idx++;
        end
        step(1'b1, 1'b0, 1'b1, 16'h00B4, 1'b1);
        chk("full_pp_in_ready", 0, 32'(bus_a.in_ready), 32'd1);
        chk("full_pp_count",    0, 32'(bus_a.count),    32'd4);
        chk("full_pp_head",     0, 32'(bus_a.out_data), 32'hB0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("full_pp_count_after", 0, 32'(bus_a.count),    32'd4);
        chk("full_pp_next",        0, 32'(bus_a.out_data), 32'hB1);
        idle(10);

        // Flush with three words inside
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'(16'h00C0 + i), 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h0077, 1'b1);
        chk("clr_in_ready",  0, 32'(bus_a.in_ready),  32'd0);
        chk("clr_out_valid", 0, 32'(bus_a.out_valid), 32'd0);
        chk("clr_count_pre", 0, 32'(bus_a.count),     32'd3);
        step(1'b1, 1'b0, 1'b1, 16'h0055, 1'b1);
        chk("clr_count_post", 0, 32'(bus_a.count),     32'd0);
        chk("clr_out_valid2", 0, 32'(bus_a.out_valid), 32'd0);
        chk("clr_out_data",   0, 32'(bus_a.out_data),  32'd0);
        chk("clr_accept",     0, 32'(bus_a.in_ready),  32'd1);
        for (int s = 1; s <= 5; s++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            if (s < 4)  chk("flush_no_stale", 0, 32'(bus_a.out_valid), 32'd0);
            if (s == 4) begin
                chk("flush_55_valid", 0, 32'(bus_a.out_valid), 32'd1);
                chk("flush_55_data",  0, 32'(bus_a.out_data),  32'h55);
            end
            if (s == 5) chk("flush_tail_empty", 0, 32'(bus_a.out_valid), 32'd0);
        end

        // Flush held several cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'(16'h00D0 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'h00EE, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0066, 1'b1);
        chk("clr_hold_accept", 0, 32'(bus_a.in_ready), 32'd1);
        chk("clr_hold_count",  0, 32'(bus_a.count),    32'd0);
        idle(10);

        // Randomised valid/ready with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            bit r;
            bit cl;
            bit v;
            bit o;
            r  = ($urandom_range(199) != 0);
            cl = ($urandom_range(39) == 0);
            v  = ($urandom_range(9) < 7);
            o  = ($urandom_range(99) < (((c / 200) % 2) ? 85 : 30));
            step(r, cl, v, 16'($urandom), o);
        end
        idle(10);

        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL check_count: got %0d comparisons, expected at least 12", n_checks);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
